// File: rtl/align_samples_pkg.sv
// Shared types and helpers for the align_samples front end: controller state
// encoding, shift-width calculation and timestamp-to-word-index conversion.
package align_samples_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CFG  = 2'd1,
        WAIT = 2'd2,
        RUN  = 2'd3
    } state_t;

    function automatic int shift_w(input int spc);
        return $clog2(spc);
    endfunction

    // Timestamps are at most 64 bits wide; the caller truncates to its index width.
    function automatic logic [63:0] word_idx(input logic [63:0] t, input int sw);
        return t >> sw;
    endfunction

endpackage

// File: rtl/align_samples_ctrl.sv
// Timed-capture controller: waits for the radio word holding sample T, configures
// align_samples for the sub-word offset and pushes exactly the words it needs.
module align_samples_ctrl
    import align_samples_pkg::*;
#(
    parameter int SAMP_W = 16,
    parameter int SPC    = 4,
    parameter int USER_W = 8,
    parameter int TIME_W = 64,
    parameter int NUM_W  = 16
) (
    input  logic                                      clk,
    input  logic                                      rst,
    input  logic [TIME_W-1:0]                         s_cmd_time,
    input  logic [NUM_W-1:0]                          s_cmd_num,
    input  logic                                      s_cmd_valid,
    output logic                                      s_cmd_ready,
    input  logic [TIME_W-1:0]                         i_time,
    input  logic [SPC*SAMP_W-1:0]                     i_data,
    input  logic [USER_W-1:0]                         i_user,
    input  logic                                      i_stb,
    output logic [SPC*SAMP_W-1:0]                     o_data,
    output logic [USER_W-1:0]                         o_user,
    output logic                                      o_push,
    output logic                                      o_cfg_en,
    output logic [((SPC > 1) ? $clog2(SPC) : 1)-1:0]  o_shift,
    output logic                                      o_dir,
    output logic                                      o_first,
    output logic                                      o_last,
    output logic                                      o_done,
    output logic                                      o_late
);

    localparam int SW  = shift_w(SPC);
    localparam int OSW = (SW > 0) ? SW : 1;
    localparam int DW  = TIME_W - SW;
    localparam int CW  = NUM_W + 1;
    localparam logic [TIME_W-1:0] LANE_MASK = TIME_W'(SPC - 1);

    state_t              state_r;
    logic [TIME_W-1:0]   t_r;
    logic [CW-1:0]       cnt_r;
    logic                ready_r;
    logic [TIME_W-1:0]   off_s;
    logic [CW-1:0]       words_s;
    logic [DW-1:0]       diff_s;
    logic                match_s;
    logic                late_s;

    // Word-distance comparator; the MSB of the modular difference marks a past start time.
    always_comb begin
        off_s   = s_cmd_time & LANE_MASK;
        words_s = CW'(s_cmd_num) + CW'(off_s != {TIME_W{1'b0}});
        diff_s  = DW'(word_idx(64'(t_r), SW) - word_idx(64'(i_time), SW));
        match_s = (diff_s == {DW{1'b0}});
        late_s  = diff_s[DW-1];
    end

    assign s_cmd_ready = ready_r;

    // Command sequencer with registered strobe outputs; cnt_r counts words still to push.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r  <= IDLE;
            t_r      <= {TIME_W{1'b0}};
            cnt_r    <= {CW{1'b0}};
            ready_r  <= 1'b0;
            o_data   <= {(SPC*SAMP_W){1'b0}};
            o_user   <= {USER_W{1'b0}};
            o_push   <= 1'b0;
            o_cfg_en <= 1'b0;
            o_shift  <= {OSW{1'b0}};
            o_dir    <= 1'b0;
            o_first  <= 1'b0;
            o_last   <= 1'b0;
            o_done   <= 1'b0;
            o_late   <= 1'b0;
        end else begin
            o_push   <= 1'b0;
            o_cfg_en <= 1'b0;
            o_first  <= 1'b0;
            o_last   <= 1'b0;
            o_done   <= 1'b0;
            o_late   <= 1'b0;
            o_dir    <= 1'b1;
            case (state_r)
                IDLE: begin
                    if (s_cmd_valid && ready_r) begin
                        t_r   <= s_cmd_time;
                        cnt_r <= words_s;
                        if (s_cmd_num == {NUM_W{1'b0}}) begin
                            o_done <= 1'b1;
                        end else begin
                            state_r  <= CFG;
                            ready_r  <= 1'b0;
                            o_cfg_en <= 1'b1;
                            o_shift  <= OSW'(off_s);
                        end
                    end else begin
                        ready_r <= 1'b1;
                    end
                end
                CFG: begin
                    // A push here would coincide with the config cycle, so a hit is as fatal as a miss.
                    if (i_stb && (match_s || late_s)) begin
                        o_late  <= 1'b1;
                        state_r <= IDLE;
                        ready_r <= 1'b1;
                    end else begin
                        state_r <= WAIT;
                    end
                end
                WAIT: begin
                    if (i_stb && match_s) begin
                        o_push  <= 1'b1;
                        o_first <= 1'b1;
                        o_data  <= i_data;
                        o_user  <= i_user;
                        if (cnt_r == CW'(1)) begin
                            o_last  <= 1'b1;
                            o_done  <= 1'b1;
                            state_r <= IDLE;
                            ready_r <= 1'b1;
                        end else begin
                            cnt_r   <= cnt_r - CW'(1);
                            state_r <= RUN;
                        end
                    end else if (i_stb && late_s) begin
                        o_late  <= 1'b1;
                        state_r <= IDLE;
                        ready_r <= 1'b1;
                    end else begin
                        state_r <= WAIT;
                    end
                end
                RUN: begin
                    if (i_stb) begin
                        o_push <= 1'b1;
                        o_data <= i_data;
                        o_user <= i_user;
                        if (cnt_r == CW'(1)) begin
                            o_last  <= 1'b1;
                            o_done  <= 1'b1;
                            state_r <= IDLE;
                            ready_r <= 1'b1;
                        end else begin
                            cnt_r <= cnt_r - CW'(1);
                        end
                    end else begin
                        state_r <= RUN;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    ready_r <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_align_samples_ctrl.sv
// Randomized bench for align_samples_ctrl: a transaction-level model predicts the
// pushed words, the done/late outcome and their cycles from the command and radio stream.
module tb_align_samples_ctrl;

    localparam int SAMP_W = 16;
    localparam int SPC    = 4;
    localparam int USER_W = 8;
    localparam int TIME_W = 64;
    localparam int NUM_W  = 16;

    logic                   clk = 1'b0;
    logic                   rst = 1'b1;
    logic [TIME_W-1:0]      s_cmd_time = '0;
    logic [NUM_W-1:0]       s_cmd_num = '0;
    logic                   s_cmd_valid = 1'b0;
    logic                   s_cmd_ready;
    logic [TIME_W-1:0]      i_time = '0;
    logic [SPC*SAMP_W-1:0]  i_data = '0;
    logic [USER_W-1:0]      i_user = '0;
    logic                   i_stb = 1'b0;
    logic [SPC*SAMP_W-1:0]  o_data;
    logic [USER_W-1:0]      o_user;
    logic                   o_push, o_cfg_en, o_dir, o_first, o_last, o_done, o_late;
    logic [1:0]             o_shift;

    align_samples_ctrl #(.SAMP_W(SAMP_W), .SPC(SPC), .USER_W(USER_W), .TIME_W(TIME_W), .NUM_W(NUM_W)) dut (
        .clk(clk), .rst(rst), .s_cmd_time(s_cmd_time), .s_cmd_num(s_cmd_num),
        .s_cmd_valid(s_cmd_valid), .s_cmd_ready(s_cmd_ready), .i_time(i_time),
        .i_data(i_data), .i_user(i_user), .i_stb(i_stb), .o_data(o_data), .o_user(o_user),
        .o_push(o_push), .o_cfg_en(o_cfg_en), .o_shift(o_shift), .o_dir(o_dir),
        .o_first(o_first), .o_last(o_last), .o_done(o_done), .o_late(o_late)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { logic [63:0] d; logic [7:0] u; logic first; logic last; int c; } push_t;
    typedef struct { logic [63:0] t; logic [63:0] d; logic [7:0] u; int c; } stb_t;

    push_t      push_q[$];
    stb_t       stb_q[$];
    int         cfg_n = 0, done_n = 0, late_n = 0, overlap_n = 0;
    int         cfg_c = 0, done_c = 0, late_c = 0;
    logic [1:0] cfg_shift = '0;
    logic       cfg_dir = 1'b0;
    int         n_err = 0;
    int         n_chk = 0;

    // Output monitor: records everything the DUT emits, sampled on the falling edge.
    always @(negedge clk) begin
        if (!rst) begin
            if (o_push) push_q.push_back('{o_data, o_user, o_first, o_last, cyc});
            if (o_cfg_en) begin
                cfg_n++; cfg_c = cyc; cfg_shift = o_shift; cfg_dir = o_dir;
            end
            if (o_cfg_en && o_push) overlap_n++;
            if (o_done) begin done_n++; done_c = cyc; end
            if (o_late) begin late_n++; late_c = cyc; end
        end
    end

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Issue one command, stream n_stb radio words from t0, then compare with the model.
    // slot0: strobe in the config cycle 0=never, 1=always, 2=random; gap_pct: idle probability.
    task automatic run_cmd(input string tag, input logic [63:0] t, input logic [15:0] n,
                           input logic [63:0] t0, input int n_stb, input int slot0, input int gap_pct);
        int p0, cfg0, done0, late0, ov0, acc_c, w, cnt, k, waited, got_n;
        int exp_done, exp_late, exp_done_c, exp_late_c;
        logic [63:0] rt;
        logic [61:0] dd;
        logic s, started;
        push_t e[$];
        stb_q.delete();
        waited = 0;
        while (s_cmd_ready !== 1'b1 && waited < 20) begin
            @(posedge clk); #1; waited++;
        end
        check_val({tag, " ready"}, 64'(s_cmd_ready), 64'd1);
        p0 = push_q.size(); cfg0 = cfg_n; done0 = done_n; late0 = late_n; ov0 = overlap_n;
        s_cmd_valid = 1'b1; s_cmd_time = t; s_cmd_num = n;
        @(posedge clk); #1;
        acc_c = cyc;
        s_cmd_valid = 1'b0; s_cmd_time = {$urandom, $urandom}; s_cmd_num = 16'($urandom);
        rt = t0; cnt = 0; k = 0;
        while (cnt < n_stb) begin
            if (k == 0) s = (slot0 == 2) ? 1'($urandom_range(0, 1)) : (slot0 == 1);
            else        s = ($urandom_range(0, 99) >= gap_pct);
            i_stb = s; i_time = rt; i_data = {$urandom, $urandom}; i_user = 8'($urandom);
            if (s) begin
                stb_q.push_back('{rt, i_data, i_user, cyc});
                rt = rt + 64'd4; cnt++;
            end
            @(posedge clk); #1; k++;
        end
        i_stb = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        // Reference model: walk the strobes applying the start/late/count rules.
        exp_done = 0; exp_late = 0; exp_done_c = 0; exp_late_c = 0; started = 1'b0;
        w = int'(n) + ((t[1:0] != 2'd0) ? 1 : 0);
        if (n == 16'd0) begin
            exp_done = 1; exp_done_c = acc_c;
        end else begin
            foreach (stb_q[i]) begin
                if (exp_done == 0 && exp_late == 0) begin
                    dd = 62'(t >> 2) - 62'(stb_q[i].t >> 2);
                    if (stb_q[i].c == acc_c) begin
                        if (dd == 62'd0 || dd[61]) begin exp_late = 1; exp_late_c = stb_q[i].c + 1; end
                    end else if (!started && dd[61]) begin
                        exp_late = 1; exp_late_c = stb_q[i].c + 1;
                    end else if (started || dd == 62'd0) begin
                        started = 1'b1;
                        e.push_back('{stb_q[i].d, stb_q[i].u, e.size() == 0, e.size() == w - 1, stb_q[i].c + 1});
                        if (e.size() == w) begin exp_done = 1; exp_done_c = stb_q[i].c + 1; end
                    end
                end
            end
        end
        got_n = push_q.size() - p0;
        check_val({tag, " push_count"}, 64'(got_n), 64'(e.size()));
        for (int i = 0; i < e.size() && i < got_n; i++) begin
            check_val({tag, " data"},  push_q[p0+i].d, e[i].d);
            check_val({tag, " user"},  64'(push_q[p0+i].u), 64'(e[i].u));
            check_val({tag, " first"}, 64'(push_q[p0+i].first), 64'(e[i].first));
            check_val({tag, " last"},  64'(push_q[p0+i].last), 64'(e[i].last));
            check_val({tag, " push_cyc"}, 64'(push_q[p0+i].c), 64'(e[i].c));
        end
        check_val({tag, " done_n"}, 64'(done_n - done0), 64'(exp_done));
        check_val({tag, " late_n"}, 64'(late_n - late0), 64'(exp_late));
        if (exp_done != 0 && done_n > done0) check_val({tag, " done_cyc"}, 64'(done_c), 64'(exp_done_c));
        if (exp_late != 0 && late_n > late0) check_val({tag, " late_cyc"}, 64'(late_c), 64'(exp_late_c));
        check_val({tag, " cfg_n"}, 64'(cfg_n - cfg0), (n != 16'd0) ? 64'd1 : 64'd0);
        if (n != 16'd0 && cfg_n > cfg0) begin
            check_val({tag, " shift"}, 64'(cfg_shift), 64'(t[1:0]));
            check_val({tag, " dir"}, 64'(cfg_dir), 64'd1);
            check_val({tag, " cfg_cyc"}, 64'(cfg_c), 64'(acc_c));
        end
        check_val({tag, " cfg_push_overlap"}, 64'(overlap_n - ov0), 64'd0);
    endtask

    initial begin
        logic [63:0] base, t;
        logic [15:0] n;
        int done0, seen;
        #3;
        check_val("rst ready", 64'(s_cmd_ready), 64'd0);
        check_val("rst outs", 64'({o_push, o_cfg_en, o_dir, o_first, o_last, o_done, o_late, o_shift}), 64'd0);
        check_val("rst data", o_data, 64'd0);
        check_val("rst user", 64'(o_user), 64'd0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        run_cmd("aligned",   64'h108, 16'd3, 64'h100, 8, 1, 0);
        run_cmd("offset",    64'h10A, 16'd2, 64'h100, 8, 1, 0);
        run_cmd("late_cfg",  64'h0F0, 16'd2, 64'h100, 4, 1, 0);
        run_cmd("late_wait", 64'h0F0, 16'd2, 64'h100, 4, 0, 0);
        run_cmd("hit_cfg",   64'h100, 16'd2, 64'h100, 4, 1, 0);
        run_cmd("wrap",      64'h4,   16'd2, 64'hFFFF_FFFF_FFFF_FFF0, 10, 1, 0);
        run_cmd("n_zero",    64'h10A, 16'd0, 64'h100, 0, 0, 0);
        run_cmd("gaps",      64'h113, 16'd5, 64'h100, 14, 2, 50);

        for (int r = 0; r < 20; r++) begin
            base = {$urandom, $urandom} & ~64'h3;
            t    = base - 64'd16 + 64'($urandom_range(0, 56));
            n    = 16'($urandom_range(0, 5));
            run_cmd("random", t, n, base, 12 + int'(n) + 4, 2, 50);
        end

        // Reset in the middle of a 4-word command, then a clean command.
        done0 = done_n;
        s_cmd_valid = 1'b1; s_cmd_time = 64'h108; s_cmd_num = 16'd4;
        @(posedge clk); #1;
        s_cmd_valid = 1'b0;
        i_time = 64'h100; seen = 0;
        for (int k = 0; k < 20 && seen == 0; k++) begin
            i_stb = 1'b1; i_data = {$urandom, $urandom};
            @(posedge clk); #1;
            i_time = i_time + 64'd4;
            if (o_push) seen = 1;
        end
        check_val("mid_rst first_push", 64'(seen), 64'd1);
        rst = 1'b1;
        #1;
        check_val("mid_rst outs", 64'({o_push, o_cfg_en, o_dir, o_first, o_last, o_done, o_late, o_shift}), 64'd0);
        check_val("mid_rst data", o_data, 64'd0);
        check_val("mid_rst ready", 64'(s_cmd_ready), 64'd0);
        repeat (3) @(posedge clk);
        #1;
        i_stb = 1'b0;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_val("mid_rst no_done", 64'(done_n - done0), 64'd0);
        run_cmd("after_rst", 64'h20A, 16'd3, 64'h1F0, 12, 0, 30);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
